// File: rtl/shl_seq_multi_pkg.sv
// shl_seq_multi_pkg: FSM state encoding and default widths for the sequential left shifter
package shl_seq_multi_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int AMT_W_DEF = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/shl1_step.sv
// shl1_step: combinational 1-bit left shift; d in, q = d<<1 with LSB 0, co = bit shifted out of MSB
module shl1_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co
);
  assign q  = {d[WIDTH-2:0], 1'b0};
  assign co = d[WIDTH-1];
endmodule

// File: rtl/shl_seq_multi.sv
// shl_seq_multi: multi-cycle left shifter, one bit per clock; in_valid/in_ready/in_data/in_amt in, out_valid/out_ready/out_data/out_ovf out, busy in SHIFT or DONE
module shl_seq_multi
  import shl_seq_multi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, step_q;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, step_co;
  shl1_step #(.WIDTH(WIDTH)) u_step (.d(data_q), .q(step_q), .co(step_co));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        cnt_d   = in_amt;
        ovf_d   = 1'b0;
        state_d = (in_amt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        data_d  = step_q;
        ovf_d   = ovf_q | step_co;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == AMT_W'(1)) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_shl_seq_multi.sv
// tb_shl_seq_multi: table-driven, directed and random checks of shl_seq_multi against an arithmetic shift model
module tb_shl_seq_multi;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic [1:0] in_amt = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [3:0] out_data;
  int n_cmp = 0, n_fail = 0;
  typedef struct {logic [3:0] d; logic [1:0] a; logic [3:0] ed; logic eo;} vec_t;
  vec_t vecs[6];
  shl_seq_multi #(.WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] ref_shl(logic [3:0] d, int a);
    logic [7:0] f;
    f = {4'b0, d} << a;
    return {|f[7:4], f[3:0]};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_job(logic [3:0] d, logic [1:0] a, logic [3:0] ed, logic eo);
    int lat;
    check("job_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_amt = a; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_amt = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("job_latency", lat, a);
    check("job_data", out_data, ed);
    check("job_ovf", out_ovf, eo);
    tick();
    check("job_idle_after", {in_ready, out_valid, busy}, 3'b100);
  endtask
  initial begin
    int hs;
    logic [4:0] m;
    logic [3:0] rd;
    logic [1:0] ra;
    vecs[0] = '{4'b0011, 2'd2, 4'b1100, 1'b0};
    vecs[1] = '{4'b1011, 2'd3, 4'b1000, 1'b1};
    vecs[2] = '{4'b1010, 2'd0, 4'b1010, 1'b0};
    vecs[3] = '{4'b0001, 2'd1, 4'b0010, 1'b0};
    vecs[4] = '{4'b0001, 2'd3, 4'b1000, 1'b0};
    vecs[5] = '{4'b1000, 2'd1, 4'b0000, 1'b1};
    tick(); tick();
    rst = 1'b0;
    check("reset_state", {in_ready, out_valid, busy, out_ovf, out_data}, 8'b1000_0000);
    for (int i = 0; i < 6; i++) run_job(vecs[i].d, vecs[i].a, vecs[i].ed, vecs[i].eo);
    in_valid = 1'b1; in_data = 4'b0110; in_amt = 2'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("midjob_busy", busy, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("midjob_reset_state", {in_ready, out_valid, busy, out_ovf, out_data}, 8'b1000_0000);
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid && out_ready) hs++;
    end
    check("midjob_no_output", hs, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0101; in_amt = 2'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("bp_done", out_valid, 1);
    in_valid = 1'b1; in_data = 4'b1111; in_amt = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stall", {out_valid, in_ready, out_ovf, out_data}, 7'b1_0_1_0100);
    end
    out_ready = 1'b1;
    tick();
    check("bp_handshake", {out_valid, in_ready}, 2'b01);
    tick();
    check("bp_capture", {busy, in_ready}, 2'b10);
    in_valid = 1'b0;
    tick();
    check("bp_result", {out_valid, out_ovf, out_data}, 6'b1_1_1110);
    tick();
    for (int i = 0; i < 40; i++) begin
      rd = 4'($urandom);
      ra = 2'($urandom);
      m = ref_shl(rd, int'(ra));
      run_job(rd, ra, m[3:0], m[4]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
